qpi_psram_responder: RTL

- Synthesizable device-side model of the ESP-PSRAM64H serial interface: the responder for our SPI/QPI PSRAM host controller.
- Oversamples sclk/ce/sio on a faster system clock, decodes the SPI and QPI commands, and serves burst reads and writes from an external byte-wide RAM port.
- Used in FPGA loopback self-test and in simulation benches in place of the real chip.

---
 rtl/qpi_psram_responder.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/qpi_psram_responder.sv
// Device-side ESP-PSRAM64H SPI/QPI responder serving a byte-wide backing RAM.
// Define PSRAM_READID_EN to answer the SPI read-ID command (0x9F).
module qpi_psram_responder #(
    parameter int ADDR_W      = 23,
    parameter int WAIT_CYCLES = 6,
    parameter int PAGE_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ce,
    input  logic [3:0]        sio_in,
    output logic [3:0]        sio_out,
    output logic [3:0]        sio_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              qpi_mode,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_ID} op_t;

    logic [2:0] sclk_sync_q;
    logic [1:0] ce_sync_q;
    logic [3:0] sio_s1_q, sio_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            ce_sync_q   <= 2'b11;
            sio_s1_q    <= '0;
            sio_s2_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            ce_sync_q   <= {ce_sync_q[0], ce};
            sio_s1_q    <= sio_in;
            sio_s2_q    <= sio_s1_q;
        end
    end

    logic rise, fall, ce_s;
    assign rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ce_s = ce_sync_q[1];

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [6:0]        sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rbuf_q, rbuf_d;
    logic [3:0]        lo_q, lo_d;
    logic              phase_q, phase_d;
    logic              rd_dly_q, rd_dly_d;
    logic              rst_en_q, rst_en_d;
    logic              qpi_pend_q, qpi_pend_d;
    logic              qpi_q, qpi_d;
    logic              busy_q, busy_d;
    logic [3:0]        out_q, out_d;
    logic [3:0]        oe_q, oe_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        wdata_q, wdata_d;
`ifdef PSRAM_READID_EN
    logic [23:0]       id_sh_q, id_sh_d;
`endif

    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_in;

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        r[PAGE_W-1:0] = a[PAGE_W-1:0] + PAGE_W'(1);
        return r;
    endfunction

    always_comb begin
        byte_in = qpi_q ? {sh_q[3:0], sio_s2_q} : {sh_q, sio_s2_q[0]};
        addr_in = qpi_q ? {addr_q[ADDR_W-5:0], sio_s2_q}
                        : {addr_q[ADDR_W-2:0], sio_s2_q[0]};

        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        addr_d     = mem_we_q ? inc(addr_q) : addr_q;
        rbuf_d     = rd_dly_q ? mem_rdata : rbuf_q;
        lo_d       = lo_q;
        phase_d    = phase_q;
        rd_dly_d   = mem_rd_q;
        rst_en_d   = rst_en_q;
        qpi_pend_d = qpi_pend_q;
        qpi_d      = qpi_q;
        busy_d     = ~ce_s;
        out_d      = out_q;
        oe_d       = oe_q;
        mem_rd_d   = 1'b0;
        mem_we_d   = 1'b0;
        wdata_d    = wdata_q;
`ifdef PSRAM_READID_EN
        id_sh_d    = id_sh_q;
`endif

        // ce high overrides any sclk edge seen in the same cycle
        if (ce_s) begin
            state_d = S_IDLE;
            oe_d    = 4'h0;
            cnt_d   = '0;
            sh_d    = '0;
            phase_d = 1'b0;
            if (qpi_pend_q) begin
                qpi_d      = 1'b1;
                qpi_pend_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_IDLE, S_CMD: begin
                    state_d = S_CMD;
                    if (rise) begin
                        sh_d  = byte_in[6:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == (qpi_q ? 5'd1 : 5'd7)) begin
                            cnt_d    = '0;
                            sh_d     = '0;
                            rst_en_d = 1'b0;
                            state_d  = S_IGNORE;
                            case (byte_in)
                                8'h66: rst_en_d = 1'b1;
                                8'h99: if (rst_en_q) begin
                                    qpi_d      = 1'b0;
                                    qpi_pend_d = 1'b0;
                                end
                                8'h35: if (!qpi_q) qpi_pend_d = 1'b1;
                                8'hF5: if (qpi_q) qpi_d = 1'b0;
                                8'h38: if (qpi_q) begin
                                    state_d = S_ADDR;
                                    op_d    = OP_WR;
                                end
                                8'hEB: if (qpi_q) begin
                                    state_d = S_ADDR;
                                    op_d    = OP_RD;
                                end
`ifdef PSRAM_READID_EN
                                8'h9F: if (!qpi_q) begin
                                    state_d = S_ADDR;
                                    op_d    = OP_ID;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        addr_d = addr_in;
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == (qpi_q ? 5'd5 : 5'd23)) begin
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            case (op_q)
                                OP_WR: state_d = S_WDATA;
                                OP_RD: begin
                                    state_d  = S_WAIT;
                                    mem_rd_d = 1'b1;
                                end
                                default: begin
`ifdef PSRAM_READID_EN
                                    state_d = S_RDATA;
                                    id_sh_d = 24'h0D5D00;
`else
                                    state_d = S_IGNORE;
`endif
                                end
                            endcase
                        end
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'(WAIT_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = S_RDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (fall) begin
`ifdef PSRAM_READID_EN
                        if (op_q == OP_ID) begin
                            oe_d    = 4'b0010;
                            out_d   = {2'b00, id_sh_q[23], 1'b0};
                            id_sh_d = {id_sh_q[22:0], 1'b0};
                        end else
`endif
                        if (!phase_q) begin
                            // low nibble is held aside; rbuf is refilled by the prefetch
                            oe_d     = 4'hF;
                            out_d    = rbuf_q[7:4];
                            lo_d     = rbuf_q[3:0];
                            addr_d   = inc(addr_q);
                            mem_rd_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            out_d   = lo_q;
                            phase_d = 1'b0;
                        end
                    end
                end
                S_WDATA: begin
                    if (rise) begin
                        if (!phase_q) begin
                            sh_d[3:0] = sio_s2_q;
                            phase_d   = 1'b1;
                        end else begin
                            wdata_d  = {sh_q[3:0], sio_s2_q};
                            mem_we_d = 1'b1;
                            phase_d  = 1'b0;
                        end
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_WR;
            cnt_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            rbuf_q     <= '0;
            lo_q       <= '0;
            phase_q    <= 1'b0;
            rd_dly_q   <= 1'b0;
            rst_en_q   <= 1'b0;
            qpi_pend_q <= 1'b0;
            qpi_q      <= 1'b0;
            busy_q     <= 1'b0;
            out_q      <= '0;
            oe_q       <= '0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            wdata_q    <= '0;
`ifdef PSRAM_READID_EN
            id_sh_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            rbuf_q     <= rbuf_d;
            lo_q       <= lo_d;
            phase_q    <= phase_d;
            rd_dly_q   <= rd_dly_d;
            rst_en_q   <= rst_en_d;
            qpi_pend_q <= qpi_pend_d;
            qpi_q      <= qpi_d;
            busy_q     <= busy_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            wdata_q    <= wdata_d;
`ifdef PSRAM_READID_EN
            id_sh_q    <= id_sh_d;
`endif
        end
    end

    assign sio_out   = out_q;
    assign sio_oe    = oe_q;
    assign mem_addr  = addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = wdata_q;
    assign qpi_mode  = qpi_q;
    assign busy      = busy_q;

endmodule
